// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter and sequencer for a single-port data RAM
// Port 0 is the cpu data side, port 1 a secondary master; one transaction in flight at a time.
module ram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              ctrl0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              ctrl1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_request,
  output logic              mem_control,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [1:0]        grant,
  output logic              busy
);

  generate
    if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
      $error("ram_arbiter: READ_LAT must be in 1..15");
    end
  endgenerate

  // ACCESS covers the first read cycle, so WAIT counts the remaining READ_LAT-1 cycles down to 0.
  localparam logic [3:0] CNT_INIT = (READ_LAT >= 2) ? 4'(READ_LAT - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_ctrl;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [3:0]        r_cnt;
  logic              w_start;
  logic              w_sel;
  logic              w_sample;
  logic              w_drive;

  always_comb begin
    w_start  = req0 | req1;
    w_sel    = (req0 && req1) ? ~r_last_grant : req1;
    w_sample = ((r_state == ACCESS) && r_ctrl && (READ_LAT == 1)) ||
               ((r_state == WAIT) && (r_cnt == 4'd0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = ACCESS;
      ACCESS:  w_next = (!r_ctrl || (READ_LAT == 1)) ? DONE : WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_ctrl       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_cnt        <= 4'd0;
    end else begin
      if (r_state == IDLE && w_start) begin
        r_owner <= w_sel;
        r_ctrl  <= w_sel ? ctrl1  : ctrl0;
        r_addr  <= w_sel ? addr1  : addr0;
        r_wdata <= w_sel ? wdata1 : wdata0;
      end
      if (r_state == ACCESS)
        r_cnt <= CNT_INIT;
      else if (r_state == WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_sample) begin
        if (r_owner) r_rdata1 <= ram_data_out;
        else         r_rdata0 <= ram_data_out;
      end
      if (r_state == DONE)
        r_last_grant <= r_owner;
    end
  end

  // Every output below decodes from registered state only.
  assign w_drive     = (r_state == ACCESS) || (r_state == WAIT);
  assign ram_request = w_drive;
  assign mem_control = w_drive & r_ctrl;
  assign address     = w_drive ? r_addr : '0;
  assign ram_data_in = (w_drive && !r_ctrl) ? r_wdata : '0;
  assign grant       = (r_state == IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
  assign busy        = (r_state != IDLE);
  assign ack0        = (r_state == DONE) && !r_owner;
  assign ack1        = (r_state == DONE) && r_owner;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
// Main instance uses READ_LAT=2; two side instances cover READ_LAT=1 and READ_LAT=4.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, ctrl0, req1, ctrl1;
  logic [11:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [7:0]  rdata0, rdata1;
  logic        ram_request, mem_control;
  logic [11:0] address;
  logic [7:0]  ram_data_in, ram_data_out;
  logic [1:0]  grant;
  logic        busy;
  logic [7:0]  mem [0:4095];

  logic        a_req [2];
  logic [11:0] a_addr [2];
  logic        a_ack [2];
  logic        a_ack_n [2];
  logic [7:0]  a_rdata [2];
  logic [7:0]  a_rdata_n [2];
  logic        a_rreq [2];
  logic        a_mctl [2];
  logic [11:0] a_address [2];
  logic [7:0]  a_din [2];
  logic [1:0]  a_grant [2];
  logic        a_busy [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(12), .DATA_W(8), .READ_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .ctrl0(ctrl0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .ctrl1(ctrl1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_request(ram_request), .mem_control(mem_control), .address(address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .grant(grant), .busy(busy)
  );

  always @(posedge clk) if (ram_request && !mem_control) mem[address] <= ram_data_in;
  assign ram_data_out = mem[address];

  ram_arbiter #(.ADDR_W(12), .DATA_W(8), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req0(a_req[0]), .ctrl0(1'b1), .addr0(a_addr[0]), .wdata0(8'h00), .ack0(a_ack[0]), .rdata0(a_rdata[0]),
    .req1(1'b0), .ctrl1(1'b0), .addr1(12'h000), .wdata1(8'h00), .ack1(a_ack_n[0]), .rdata1(a_rdata_n[0]),
    .ram_request(a_rreq[0]), .mem_control(a_mctl[0]), .address(a_address[0]),
    .ram_data_in(a_din[0]), .ram_data_out(a_address[0][7:0] ^ 8'h5A), .grant(a_grant[0]), .busy(a_busy[0])
  );

  ram_arbiter #(.ADDR_W(12), .DATA_W(8), .READ_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst),
    .req0(a_req[1]), .ctrl0(1'b1), .addr0(a_addr[1]), .wdata0(8'h00), .ack0(a_ack[1]), .rdata0(a_rdata[1]),
    .req1(1'b0), .ctrl1(1'b0), .addr1(12'h000), .wdata1(8'h00), .ack1(a_ack_n[1]), .rdata1(a_rdata_n[1]),
    .ram_request(a_rreq[1]), .mem_control(a_mctl[1]), .address(a_address[1]),
    .ram_data_in(a_din[1]), .ram_data_out(a_address[1][7:0] ^ 8'h5A), .grant(a_grant[1]), .busy(a_busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Runs one transaction on a port, returns ticks from request to ack, leaves the DUT in IDLE.
  task automatic run_xact(input bit port, input bit ctrl, input logic [11:0] addr,
                          input logic [7:0] wd, output int lat);
    bit done = 1'b0;
    lat = 0;
    if (port == 1'b0) begin req0 = 1'b1; ctrl0 = ctrl; addr0 = addr; wdata0 = wd; end
    else              begin req1 = 1'b1; ctrl1 = ctrl; addr1 = addr; wdata1 = wd; end
    for (int i = 1; i <= 20 && !done; i++) begin
      tick();
      if ((port == 1'b0 && ack0) || (port == 1'b1 && ack1)) begin
        lat  = i;
        done = 1'b1;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    if (!done) chk("xact_timeout", 32'd0, 32'd1);
    tick();
  endtask

  logic [1:0] exp_order [6];
  int lat;
  int nack;
  int last_tick;
  int rreq_cnt [2];
  int ack_tick [2];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b0;
    req0 = 0; ctrl0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; ctrl1 = 0; addr1 = 0; wdata1 = 0;
    a_req = '{1'b0, 1'b0};
    a_addr = '{12'h0AB, 12'h123};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ram_request", ram_request, 0);
    chk("rst_address", address, 0);
    chk("rst_acks", {ack0, ack1}, 0);
    chk("rst_rdata", {rdata0, rdata1}, 0);
    rst = 1'b1;
    tick();

    // Port 0 write; inputs changed after the grant edge must be ignored.
    req0 = 1; ctrl0 = 0; addr0 = 12'h010; wdata0 = 8'hA5;
    tick();
    chk("wr_access", {ram_request, mem_control, address, ram_data_in}, {1'b1, 1'b0, 12'h010, 8'hA5});
    chk("wr_grant_access", grant, 2'b01);
    chk("wr_no_early_ack", ack0, 0);
    addr0 = 12'h7FF; wdata0 = 8'h00;
    tick();
    chk("wr_done", {ack0, ack1, ram_request, address}, {1'b1, 1'b0, 1'b0, 12'h000});
    chk("wr_grant_done", grant, 2'b01);
    req0 = 0;
    tick();
    chk("wr_idle", {ack0, busy, grant}, 0);
    chk("wr_mem", mem[12'h010], 8'hA5);

    // Port 1 read with READ_LAT=2.
    mem[12'h020] = 8'h3C;
    req1 = 1; ctrl1 = 1; addr1 = 12'h020; wdata1 = 8'hFF;
    tick();
    chk("rd_access", {ram_request, mem_control, address, ram_data_in}, {1'b1, 1'b1, 12'h020, 8'h00});
    chk("rd_grant", grant, 2'b10);
    tick();
    chk("rd_wait", {ram_request, ack1, busy}, {1'b1, 1'b0, 1'b1});
    tick();
    chk("rd_done", {ack1, ack0, ram_request}, {1'b1, 1'b0, 1'b0});
    chk("rd_rdata1", rdata1, 8'h3C);
    chk("rd_rdata0_kept", rdata0, 8'h00);
    req1 = 0;
    tick();

    run_xact(1'b0, 1'b1, 12'h010, 8'h00, lat);
    chk("rd0_latency", lat, 3);
    chk("rd0_data", rdata0, 8'hA5);
    chk("rd0_rdata1_kept", rdata1, 8'h3C);
    run_xact(1'b1, 1'b0, 12'h020, 8'h99, lat);
    chk("wr1_latency", lat, 2);
    chk("wr1_rdata1_kept", rdata1, 8'h3C);

    // Tie after reset: port 0 first, then strict alternation at a 3-cycle write period.
    do_reset();
    req0 = 1; ctrl0 = 0; addr0 = 12'h100; wdata0 = 8'h11;
    req1 = 1; ctrl1 = 0; addr1 = 12'h200; wdata1 = 8'h22;
    nack = 0; last_tick = 0;
    for (int i = 1; i <= 40 && nack < 6; i++) begin
      tick();
      if (ack0 || ack1) begin
        chk($sformatf("tie_grant%0d", nack), grant, exp_order[nack]);
        nack++;
        last_tick = i;
      end
    end
    req0 = 0; req1 = 0;
    chk("tie_count", nack, 6);
    chk("tie_period", last_tick, 17);
    tick();

    // Starvation: req1 rises during a port-0 transaction and must win the next grant.
    req0 = 1; ctrl0 = 0; addr0 = 12'h300; wdata0 = 8'h33;
    tick();
    chk("starve_first", grant, 2'b01);
    req1 = 1; ctrl1 = 0; addr1 = 12'h301; wdata1 = 8'h44;
    tick();
    chk("starve_ack0", ack0, 1);
    tick();
    chk("starve_idle", grant, 2'b00);
    tick();
    chk("starve_next", grant, 2'b10);
    tick();
    chk("starve_ack1", ack1, 1);
    req1 = 0;
    tick();
    tick();
    chk("starve_back0", grant, 2'b01);
    req0 = 0;
    tick();
    tick();
    chk("starve_mem", {mem[12'h300], mem[12'h301]}, 16'h3344);

    // Reset during WAIT aborts asynchronously with no ack.
    mem[12'h030] = 8'h77;
    req0 = 1; ctrl0 = 1; addr0 = 12'h030;
    tick();
    tick();
    chk("abort_in_wait", {busy, ram_request}, 2'b11);
    rst = 1'b0;
    #1;
    chk("abort_async", {busy, grant, ram_request, ack0}, 0);
    req0 = 0;
    tick();
    rst = 1'b1;
    nack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack0 || ack1) nack++;
    end
    chk("abort_no_ack", nack, 0);
    run_xact(1'b0, 1'b1, 12'h030, 8'h00, lat);
    chk("abort_fresh_lat", lat, 3);
    chk("abort_fresh_data", rdata0, 8'h77);

    // READ_LAT=1 and READ_LAT=4 side instances.
    rreq_cnt = '{0, 0};
    ack_tick = '{0, 0};
    a_req = '{1'b1, 1'b1};
    for (int i = 1; i <= 12; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (a_rreq[k]) rreq_cnt[k]++;
        if (a_ack[k] && ack_tick[k] == 0) begin
          ack_tick[k] = i;
          a_req[k] = 1'b0;
        end
      end
    end
    chk("lat1_ack_tick", ack_tick[0], 2);
    chk("lat1_rreq_width", rreq_cnt[0], 1);
    chk("lat1_data", a_rdata[0], 8'hF1);
    chk("lat4_ack_tick", ack_tick[1], 5);
    chk("lat4_rreq_width", rreq_cnt[1], 4);
    chk("lat4_data", a_rdata[1], 8'h79);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 8-bit data RAM.
- Port 0 is the cpu data side. Port 1 is a secondary master (program loader / DMA / debug).
- Grants one transaction at a time, using round-robin on ties.
- Drives the RAM request/control/address/data lines, waits the fixed read latency, then returns an ack pulse and the read data to the owner.

Parameters:
- ADDR_W, 12, address width for both requesters and the RAM side.
- DATA_W, 8, data width.
- READ_LAT, 2, cycles ram_request is held for a read before ram_data_out is sampled; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0  in  1  port 0 transaction request; held until ack0.
- ctrl0  in  1  port 0 direction: 0 = write, 1 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 completion pulse, 1 cycle.
- rdata0  out  DATA_W  port 0 read data, valid from ack0 onward.
- req1, ctrl1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- ram_request  out  1  RAM access strobe.
- mem_control  out  1  RAM direction: 0 = write, 1 = read.
- address  out  ADDR_W  RAM address.
- ram_data_in  out  DATA_W  RAM write data.
- ram_data_out  in  DATA_W  RAM read data.
- grant  out  2  one-hot owner of the current transaction; 00 when idle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, ACCESS, WAIT, DONE.
- Reset (rst = 0, asynchronous): state = IDLE, last_grant = 1 (so port 0 wins the first tie), ack0/ack1 = 0, rdata0/rdata1 = 0, grant = 00, busy = 0, RAM outputs = 0, wait counter = 0.
  - Reset mid-transaction aborts it with no ack. The RAM write is not guaranteed to have happened.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: select that port.
  - Both req: select the port != last_grant.
  - On the selecting edge, latch the port index, ctrl, addr and wdata, then go to ACCESS.
- ACCESS (1 cycle):
  - ram_request = 1, mem_control = latched ctrl, address = latched addr.
  - ram_data_in = latched wdata for writes, 0 for reads.
  - Write: next state DONE.
  - Read: if READ_LAT = 1, sample ram_data_out into the owner's rdata on the exit edge and go to DONE. Otherwise load counter = READ_LAT-2 and go to WAIT.
- WAIT:
  - RAM outputs held exactly as in ACCESS.
  - Counter decrements each cycle.
  - When counter = 0: sample ram_data_out into the owner's rdata register on that edge, then go to DONE.
- DONE (1 cycle):
  - ack of the owner = 1, ram_request = 0.
  - last_grant <= owner; next state IDLE.
  - rdata of the other port is unchanged.
- Outside ACCESS/WAIT, ram_request, mem_control, address and ram_data_in are all 0.
- RAM-side outputs, grant, busy and ack decode only from registered state. There is no combinational path from req/addr inputs to outputs.
- grant is one-hot of the owner in ACCESS, WAIT and DONE.
- Latency from req sampled in IDLE (cycle t):
  - Write: ack at cycle t+2.
  - Read: ack at cycle t+1+READ_LAT.
  - Minimum transaction period per grant: 3 cycles (write) or 2+READ_LAT cycles (read).
- Requester rules:
  - Keep ctrl/addr/wdata stable only until the grant edge. Later changes are ignored.
  - Dropping req after the grant does not cancel; the ack is still issued.
  - req still high in the IDLE cycle after ack is a new transaction.
- Fairness: with both req continuously high, grants strictly alternate 0,1,0,1… No port waits more than one foreign transaction.
- rdata of a port holds its last read value until that port's next read completes. Writes leave rdata unchanged.
- An out-of-range READ_LAT is a synthesis-time error (generate guard).

Test Plan:
- Port 0 write: req0 = 1, ctrl0 = 0, addr0 = 0x010, wdata0 = 0xA5 at t → ram_request = 1, mem_control = 0, address = 0x010, ram_data_in = 0xA5 at t+1 only; ack0 pulse at t+2; grant = 01 at t+1..t+2.
- Port 1 read, READ_LAT = 2: RAM model returns 0x3C at 0x020; req1 = 1, ctrl1 = 1 at t → ram_request high at t+1..t+2; ack1 at t+3; rdata1 = 0x3C; rdata0 unchanged.
- Tie after reset: req0 and req1 rise together → port 0 served first, then port 1. With both held high for 6 transactions → grant order 01,10,01,10,01,10.
- Starvation check: req0 held high continuously, req1 raised mid port-0 transaction → the very next grant is port 1.
- Reset mid-read: rst = 0 during WAIT → asynchronously state = IDLE, busy = 0, grant = 00, ram_request = 0, no ack. After release, a fresh req0 completes normally.
- READ_LAT = 1 and READ_LAT = 4 builds: read ack at t+2 and t+5 respectively; ram_request width 1 and 4 cycles; data sampled correctly.
